// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: word width, master ids and
// the default lock bound.
package dmem_arbiter_pkg;

  localparam int unsigned WORD_LEN = 32;

  // Master id encodings
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // Default maximum consecutive locked cycles
  localparam int unsigned DMEM_ARB_MAX_LOCK = 16;

endpackage

// File: rtl/arb_lock_timer.sv
// Bus-lock bookkeeping for dmem_arbiter: lock owner, validity and a saturating
// age counter. Flags expiry when the lock has run MAX_LOCK cycles while the
// other master is waiting, and pulses lock_abort on the following cycle.
module arb_lock_timer
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK = DMEM_ARB_MAX_LOCK,
  parameter int unsigned CNT_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m0_req,
  input  logic m1_req,
  input  logic beat,
  input  logic beat_id,
  input  logic beat_lock,
  output logic lock_valid,
  output logic lock_owner,
  output logic expiring,
  output logic lock_abort
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             nonowner_req;
  logic             held;

  // Expiry detection and saturating counter increment
  always_comb begin
    nonowner_req = (lock_owner == ARB_M0) ? m1_req : m0_req;
    expiring     = lock_valid && (lock_cnt == MAX_CNT) && nonowner_req;
    held         = lock_valid && !expiring;
    cnt_inc      = (lock_cnt == MAX_CNT) ? lock_cnt : lock_cnt + 1'b1;
  end

  // Lock establish / renew / release; an expiring lock is dropped first so a
  // locked beat from the newly granted master starts a fresh lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid <= 1'b0;
      lock_owner <= ARB_M0;
      lock_cnt   <= '0;
      lock_abort <= 1'b0;
    end else begin
      lock_abort <= expiring;
      if (beat && beat_lock) begin
        lock_valid <= 1'b1;
        if (held && (lock_owner == beat_id)) begin
          lock_cnt <= cnt_inc;
        end else begin
          lock_owner <= beat_id;
          lock_cnt   <= '0;
        end
      end else if (beat && held && (lock_owner == beat_id)) begin
        lock_valid <= 1'b0;
        lock_cnt   <= '0;
      end else if (held) begin
        lock_cnt <= cnt_inc;
      end else begin
        lock_valid <= 1'b0;
        lock_cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data-memory/UART slave port.
// Master 0: core data port. Master 1: UART program loader.
// Build option DMEM_ARB_RR_EN: defined selects round-robin tie-breaking,
// undefined selects fixed priority for master 0.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK = DMEM_ARB_MAX_LOCK,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_wen,
  input  logic                m0_lock,
  input  logic [WORD_LEN-1:0] m0_addr,
  input  logic [WORD_LEN-1:0] m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [WORD_LEN-1:0] m0_rdata,
  input  logic                m1_req,
  input  logic                m1_wen,
  input  logic                m1_lock,
  input  logic [WORD_LEN-1:0] m1_addr,
  input  logic [WORD_LEN-1:0] m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [WORD_LEN-1:0] m1_rdata,
  output logic [WORD_LEN-1:0] s_addr,
  output logic                s_wen,
  output logic [WORD_LEN-1:0] s_wdata,
  input  logic [WORD_LEN-1:0] s_rdata,
  output logic                lock_abort
);

`ifdef DMEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic lock_valid;
  logic lock_owner;
  logic expiring;
  logic last_gnt;
  logic rd_pend;
  logic rd_owner;
  logic beat;
  logic beat_id;
  logic beat_lock;
  logic tie_m1;

  arb_lock_timer #(
    .MAX_LOCK (MAX_LOCK),
    .CNT_W    (CNT_W)
  ) u_lock_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .beat       (beat),
    .beat_id    (beat_id),
    .beat_lock  (beat_lock),
    .lock_valid (lock_valid),
    .lock_owner (lock_owner),
    .expiring   (expiring),
    .lock_abort (lock_abort)
  );

  // Grant selection: live lock, then forced hand-over on expiry, then tie policy
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    tie_m1 = RR_EN && (last_gnt == ARB_M0);
    if (!rst_n) begin
      m0_gnt = 1'b0;
    end else if (lock_valid && !expiring) begin
      if (lock_owner == ARB_M0) m0_gnt = m0_req;
      else                      m1_gnt = m1_req;
    end else if (expiring) begin
      if (lock_owner == ARB_M0) m1_gnt = 1'b1;
      else                      m0_gnt = 1'b1;
    end else if (m0_req && m1_req) begin
      m1_gnt = tie_m1;
      m0_gnt = !tie_m1;
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end
  end

  // Slave-port mux; master 0 drives address/data when idle
  always_comb begin
    beat      = (m0_req && m0_gnt) || (m1_req && m1_gnt);
    beat_id   = m1_gnt ? ARB_M1 : ARB_M0;
    beat_lock = m1_gnt ? m1_lock : m0_lock;
    s_addr    = m1_gnt ? m1_addr : m0_addr;
    s_wdata   = m1_gnt ? m1_wdata : m0_wdata;
    s_wen     = beat && (m1_gnt ? m1_wen : m0_wen);
  end

  // Read ownership for the one-cycle slave latency, and last winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= ARB_M0;
      last_gnt <= ARB_M1;
    end else begin
      rd_pend <= beat && !s_wen;
      if (beat) begin
        rd_owner <= beat_id;
        last_gnt <= beat_id;
      end
    end
  end

  assign m0_rvalid = rd_pend && (rd_owner == ARB_M0);
  assign m1_rvalid = rd_pend && (rd_owner == ARB_M1);
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic,
// each cycle compared against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned MAXL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_wen, m0_lock, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wen, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_wen, lock_abort;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // model state
  bit          mlk, mown, mlast, mpend, mpown, mabort;
  int unsigned mage;
  logic [31:0] mpaddr;

  // scenario tallies
  int unsigned g1_count, abort_count;

  always #5 clk = ~clk;

  // slave: read data is a fixed scramble of last cycle's address
  always @(posedge clk) s_rdata <= s_addr ^ 32'h5A5A_5A5A;

  dmem_arbiter #(
    .MAX_LOCK (MAXL),
    .CNT_W    (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_req     (m0_req),
    .m0_wen     (m0_wen),
    .m0_lock    (m0_lock),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_wen     (m1_wen),
    .m1_lock    (m1_lock),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .s_addr     (s_addr),
    .s_wen      (s_wen),
    .s_wdata    (s_wdata),
    .s_rdata    (s_rdata),
    .lock_abort (lock_abort)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_m0(input bit req, input bit wen, input bit lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_wen = wen; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic set_m1(input bit req, input bit wen, input bit lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_wen = wen; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic model_reset();
    mlk = 0; mown = 0; mage = 0; mlast = 1; mpend = 0; mpown = 0; mabort = 0;
    mpaddr = '0;
  endtask

  // One bus cycle: entered at negedge with inputs already driven
  task automatic step();
    bit [1:0]    req, g, wen, lck;
    bit          exp_ing, still, acc, x, lk_n, own_n;
    int unsigned age_n;
    logic [31:0] addr_x, wd_x;
    #1;
    req = {m1_req, m0_req};
    wen = {m1_wen, m0_wen};
    lck = {m1_lock, m0_lock};
    g   = 2'b00;
    exp_ing = mlk && (mage >= MAXL) && req[!mown];
    if (mlk && !exp_ing)     g[mown] = req[mown];
    else if (exp_ing)        g[!mown] = 1'b1;
    else if (req == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      g[!mlast] = 1'b1;
`else
      g[0] = 1'b1;
`endif
    end else                 g = req;
    acc    = |g;
    x      = g[1];
    addr_x = x ? m1_addr : m0_addr;
    wd_x   = x ? m1_wdata : m0_wdata;

    check_eq("m0_gnt", m0_gnt, g[0]);
    check_eq("m1_gnt", m1_gnt, g[1]);
    check_eq("s_wen", s_wen, acc && wen[x]);
    check_eq("s_addr", s_addr, addr_x);
    check_eq("s_wdata", s_wdata, wd_x);
    check_eq("m0_rvalid", m0_rvalid, mpend && !mpown);
    check_eq("m1_rvalid", m1_rvalid, mpend && mpown);
    if (mpend && !mpown) check_eq("m0_rdata", m0_rdata, mpaddr ^ 32'h5A5A_5A5A);
    if (mpend && mpown)  check_eq("m1_rdata", m1_rdata, mpaddr ^ 32'h5A5A_5A5A);
    check_eq("lock_abort", lock_abort, mabort);
    if (m1_gnt) g1_count++;
    if (lock_abort) abort_count++;

    @(posedge clk);
    mabort = exp_ing;
    still  = mlk && !exp_ing;
    lk_n   = still;
    own_n  = mown;
    age_n  = still ? ((mage < MAXL) ? mage + 1 : MAXL) : 0;
    if (acc) begin
      if (lck[x]) begin
        if (!(still && mown == x)) begin
          lk_n = 1; own_n = x; age_n = 0;
        end
      end else if (still && mown == x) begin
        lk_n = 0; age_n = 0;
      end
      mlast = x;
    end
    mlk    = lk_n;
    mown   = own_n;
    mage   = age_n;
    mpend  = acc && !wen[x];
    mpown  = x;
    mpaddr = addr_x;
    @(negedge clk);
  endtask

  // Assert reset at a negedge, check outputs forced idle, release later
  task automatic reset_phase(input int unsigned cycles);
    rst_n = 1'b0;
    #1;
    check_eq("rst_m0_gnt", m0_gnt, 1'b0);
    check_eq("rst_m1_gnt", m1_gnt, 1'b0);
    check_eq("rst_m0_rvalid", m0_rvalid, 1'b0);
    check_eq("rst_m1_rvalid", m1_rvalid, 1'b0);
    check_eq("rst_lock_abort", lock_abort, 1'b0);
    model_reset();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_m0(1, 0, 0, 32'h100, '0);
    set_m1(1, 0, 0, 32'h200, '0);
    model_reset();
    @(negedge clk);

    // reset with both requests held, then continuous reads from both
    reset_phase(3);
    repeat (6) step();

    // m1 write while m0 idle, then an idle cycle with no rvalid
    set_m0(0, 0, 0, 32'h100, '0);
    set_m1(1, 1, 0, 32'h0, 32'hDEAD_BEEF);
    step();
    set_m1(0, 0, 0, 32'h0, '0);
    step();

    // m0 locked read, idle, unlocked write while m1 requests throughout
    set_m1(1, 0, 0, 32'h300, '0);
    set_m0(1, 0, 1, 32'h40, '0);
    step();
    set_m0(0, 0, 0, 32'h40, '0);
    step();
    set_m0(1, 1, 0, 32'h40, 32'h1234_5678);
    step();
    set_m0(0, 0, 0, 32'h40, '0);
    step();
    set_m1(0, 0, 0, 32'h300, '0);
    step();

    // m1 holds lock while m0 waits: bounded hold, one abort pulse
    set_m1(1, 0, 1, 32'h500, '0);
    g1_count = 0;
    abort_count = 0;
    step();
    set_m0(1, 0, 0, 32'h600, '0);
    repeat (5) step();
    check_eq("lock_hold_m1_grants", g1_count, 5);
    repeat (2) step();
    check_eq("lock_abort_pulses", abort_count, 1);

    // release any remaining lock with an unlocked beat
    set_m0(0, 0, 0, 32'h600, '0);
    set_m1(1, 0, 0, 32'h510, '0);
    step();
    set_m1(0, 0, 0, 32'h510, '0);
    step();

    // reset right after a locked m0 read grant
    set_m0(1, 0, 1, 32'h700, '0);
    step();
    set_m0(0, 0, 0, 32'h700, '0);
    reset_phase(2);
    set_m1(1, 1, 0, 32'h10, 32'h55);
    step();
    set_m1(0, 0, 0, 32'h10, '0);
    step();

    // random traffic
    repeat (400) begin
      set_m0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, 32'($urandom_range(0, 255)) << 2, $urandom);
      set_m1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, 32'($urandom_range(0, 255)) << 2, $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
